// File: rtl/single_super_pixel_if.sv
// Column readout daisy-chain link: words from upstream, ready from downstream.
interface single_super_pixel_if;
  logic [25:0] last_data;
  logic        shake_hands_next;
  logic        shake_hands_last;
  logic [25:0] arbiter_data;

  modport slave (
    input  last_data,
    input  shake_hands_next,
    output shake_hands_last,
    output arbiter_data
  );

  modport master (
    output last_data,
    output shake_hands_next,
    input  shake_hands_last,
    input  arbiter_data
  );
endinterface

// File: rtl/single_super_pixel.sv
// Digital back-end of one 8-pixel super pixel: config chain, ToA/ToT or event counting, readout merge.
// Test-pulse injection and analog pulse gating exist only when SUPER_PIXEL_TEST_PULSE_EN is defined.
module single_super_pixel (
  input  logic        clk_40MHz,
  input  logic        rst,
  input  logic        rst_n_pixel,
  input  logic        mode,
  input  logic        shutter,
  input  logic        Dpulse,
  input  logic        Apulse_en,
  input  logic [8:0]  TimeStamp,
  input  logic [7:0]  hit,
  input  logic [5:0]  config_info,
  input  logic        addr_col,
  output logic [5:0]  next_config_info,
  output logic [3:0]  config_DAC_0,
  output logic [3:0]  config_DAC_1,
  output logic [3:0]  config_DAC_2,
  output logic [3:0]  config_DAC_3,
  output logic [3:0]  config_DAC_4,
  output logic [3:0]  config_DAC_5,
  output logic [3:0]  config_DAC_6,
  output logic [3:0]  config_DAC_7,
  output logic [7:0]  Apulse_en_super_pixel,
  single_super_pixel_if.slave ro
);
  localparam int unsigned NPIX   = 8;
  localparam int unsigned CFG_W  = 6;
  localparam int unsigned DAC_W  = 4;
  localparam int unsigned TOT_W  = 11;
  localparam int unsigned DAT_W  = 20;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned WORD_W = 26;

  typedef enum logic [1:0] {PX_IDLE, PX_MEAS, PX_PEND} px_state_e;

  logic [NPIX-1:0][CFG_W-1:0] cfg_q;
  logic [CFG_W-1:0]           next_cfg_q;
  logic [NPIX-1:0][DAC_W-1:0] dac_q;
  logic [NPIX-1:0]            apulse_q;
  logic [NPIX-1:0]            sync1_q, sync2_q, eff_q;
  logic [NPIX-1:0]            pix_en, tp_en, eff, rise, fall;
  logic                       shutter_q, shutter_fall;
  px_state_e                  state_q [NPIX];
  px_state_e                  state_d [NPIX];
  logic [NPIX-1:0][DAT_W-1:0] data_q, data_d;
  logic [NPIX-1:0]            pend, take;
  logic                       local_valid, found;
  logic [IDX_W-1:0]           sel;
  logic [WORD_W-1:0]          arb_q, arb_d;

  // Config chain shifts only during pixel clear; DAC codes follow the chain only once it is stable.
  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      cfg_q      <= '0;
      next_cfg_q <= '0;
      dac_q      <= '0;
    end else if (!rst_n_pixel) begin
      cfg_q      <= {cfg_q[NPIX-2:0], config_info};
      next_cfg_q <= cfg_q[NPIX-1];
    end else begin
      for (int unsigned i = 0; i < NPIX; i++) dac_q[i] <= cfg_q[i][DAC_W-1:0];
    end
  end

  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      apulse_q <= '0;
    end else begin
`ifdef SUPER_PIXEL_TEST_PULSE_EN
      apulse_q <= tp_en & {NPIX{Apulse_en}};
`else
      apulse_q <= '0;
`endif
    end
  end

  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      eff_q     <= '0;
      shutter_q <= 1'b0;
    end else begin
      sync1_q   <= hit;
      sync2_q   <= sync1_q;
      eff_q     <= eff;
      shutter_q <= shutter;
    end
  end

  always_comb begin
    pix_en = '0;
    tp_en  = '0;
    for (int unsigned i = 0; i < NPIX; i++) begin
      pix_en[i] = cfg_q[i][5];
      tp_en[i]  = cfg_q[i][4];
    end
`ifdef SUPER_PIXEL_TEST_PULSE_EN
    eff = pix_en & (sync2_q | (tp_en & {NPIX{Dpulse}}));
`else
    eff = pix_en & sync2_q;
`endif
    rise         = eff & ~eff_q;
    fall         = ~eff & eff_q;
    shutter_fall = shutter_q & ~shutter;
  end

`ifndef SUPER_PIXEL_TEST_PULSE_EN
  logic tp_unused;
  assign tp_unused = ^{Dpulse, Apulse_en, tp_en};
`endif

  // Lowest-index pending pixel wins; a pixel clear hides pending words from the arbiter.
  always_comb begin
    pend  = '0;
    sel   = '0;
    found = 1'b0;
    take  = '0;
    for (int unsigned i = 0; i < NPIX; i++) begin
      pend[i] = (state_q[i] == PX_PEND);
      if (pend[i] && !found) begin
        sel   = IDX_W'(i);
        found = 1'b1;
      end
    end
    local_valid = rst_n_pixel & found;
    if (ro.shake_hands_next && local_valid) take[sel] = 1'b1;
    arb_d = arb_q;
    if (ro.shake_hands_next) begin
      if (local_valid)             arb_d = {1'b1, addr_col, sel, mode, data_q[sel]};
      else if (ro.last_data[25])   arb_d = ro.last_data;
      else                         arb_d = '0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NPIX; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      if (!rst_n_pixel || take[i]) begin
        state_d[i] = PX_IDLE;
        data_d[i]  = '0;
      end else if (!mode) begin
        case (state_q[i])
          PX_IDLE: if (rise[i]) begin
            state_d[i] = PX_MEAS;
            data_d[i]  = {TimeStamp, TOT_W'(0)};
          end
          PX_MEAS: begin
            // ToT counts every cycle the hit was seen high, including the one ending it.
            if (data_q[i][TOT_W-1:0] != '1)
              data_d[i][TOT_W-1:0] = data_q[i][TOT_W-1:0] + TOT_W'(1);
            if (fall[i]) state_d[i] = PX_PEND;
          end
          default: ;
        endcase
      end else begin
        case (state_q[i])
          PX_IDLE: begin
            if (shutter && rise[i] && data_q[i] != '1) data_d[i] = data_q[i] + DAT_W'(1);
            if (shutter_fall && pix_en[i] && data_q[i] != '0) state_d[i] = PX_PEND;
          end
          PX_MEAS: begin
            state_d[i] = PX_IDLE;
            data_d[i]  = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      for (int unsigned i = 0; i < NPIX; i++) state_q[i] <= PX_IDLE;
      data_q <= '0;
      arb_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NPIX; i++) state_q[i] <= state_d[i];
      data_q <= data_d;
      arb_q  <= arb_d;
    end
  end

  assign ro.shake_hands_last    = ro.shake_hands_next & ~local_valid;
  assign ro.arbiter_data        = arb_q;
  assign next_config_info       = next_cfg_q;
  assign Apulse_en_super_pixel  = apulse_q;
  assign config_DAC_0           = dac_q[0];
  assign config_DAC_1           = dac_q[1];
  assign config_DAC_2           = dac_q[2];
  assign config_DAC_3           = dac_q[3];
  assign config_DAC_4           = dac_q[4];
  assign config_DAC_5           = dac_q[5];
  assign config_DAC_6           = dac_q[6];
  assign config_DAC_7           = dac_q[7];
endmodule

// File: tb/tb_single_super_pixel.sv
// Scoreboard bench for single_super_pixel: expected readout words are queued as hits are driven.
module tb_single_super_pixel;
  logic       clk_40MHz = 1'b0;
  logic       rst, rst_n_pixel, mode, shutter, Dpulse, Apulse_en, addr_col;
  logic [8:0] ts = 9'd0;
  logic [7:0] hit;
  logic [5:0] config_info, next_config_info, cfg_word;
  logic [3:0] dac [8];
  logic [7:0] apulse;
  logic [8:0] t0;
  logic [25:0] up_w;
  logic [25:0] sb [$];
  int n_checks = 0;
  int n_errors = 0;

  single_super_pixel_if ro();

  single_super_pixel dut (
    .clk_40MHz(clk_40MHz), .rst(rst), .rst_n_pixel(rst_n_pixel), .mode(mode),
    .shutter(shutter), .Dpulse(Dpulse), .Apulse_en(Apulse_en), .TimeStamp(ts),
    .hit(hit), .config_info(config_info), .addr_col(addr_col),
    .next_config_info(next_config_info),
    .config_DAC_0(dac[0]), .config_DAC_1(dac[1]), .config_DAC_2(dac[2]), .config_DAC_3(dac[3]),
    .config_DAC_4(dac[4]), .config_DAC_5(dac[5]), .config_DAC_6(dac[6]), .config_DAC_7(dac[7]),
    .Apulse_en_super_pixel(apulse), .ro(ro)
  );

  always #10 clk_40MHz = ~clk_40MHz;
  always @(posedge clk_40MHz) ts <= ts + 9'd1;

  task automatic check(input string tag, input logic [25:0] act, input logic [25:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [25:0] w0(input logic [2:0] idx, input logic [8:0] toa, input logic [10:0] tot);
    return {1'b1, addr_col, idx, 1'b0, toa, tot};
  endfunction

  function automatic logic [25:0] w1(input logic [2:0] idx, input logic [19:0] cnt);
    return {1'b1, addr_col, idx, 1'b1, cnt};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_40MHz);
  endtask

  task automatic ready(input int n);
    ro.shake_hands_next = 1'b1;
    tick(n);
    ro.shake_hands_next = 1'b0;
  endtask

  task automatic load_cfg(input logic [5:0] w);
    rst_n_pixel = 1'b0;
    config_info = w;
    tick(8);
    rst_n_pixel = 1'b1;
    tick(1);
    cfg_word = w;
  endtask

  // Every ready cycle loads arbiter_data: next queued word, or 0 when nothing is expected.
  always @(posedge clk_40MHz) begin
    logic [25:0] exp_w;
    if (!rst && ro.shake_hands_next) begin
      #1;
      exp_w = (sb.size() > 0) ? sb.pop_front() : 26'd0;
      check("arb_word", ro.arbiter_data, exp_w);
    end
  end

  initial begin
    rst = 1'b1; rst_n_pixel = 1'b1; mode = 1'b0; shutter = 1'b0; Dpulse = 1'b0;
    Apulse_en = 1'b0; addr_col = 1'b1; hit = '0; config_info = '0; cfg_word = '0;
    ro.last_data = '0; ro.shake_hands_next = 1'b0;
    tick(3);
    check("rst_arb", ro.arbiter_data, 26'd0);
    check("rst_next_cfg", 26'(next_config_info), 26'd0);
    check("rst_dac0", 26'(dac[0]), 26'd0);
    check("rst_apulse", 26'(apulse), 26'd0);
    rst = 1'b0;
    tick(1);
    check("shl_low", 26'(ro.shake_hands_last), 26'd0);
    ro.shake_hands_next = 1'b1;
    #1 check("shl_follow", 26'(ro.shake_hands_last), 26'd1);
    tick(1);
    ro.shake_hands_next = 1'b0;

    // config chain: first word emerges after the ninth shift
    rst_n_pixel = 1'b0;
    config_info = 6'b111100;
    tick(8);
    check("cfg_out_8", 26'(next_config_info), 26'd0);
    check("dac_hold_shift", 26'(dac[0]), 26'd0);
    tick(1);
    check("cfg_out_9", 26'(next_config_info), 26'(6'b111100));
    rst_n_pixel = 1'b1;
    cfg_word = 6'b111100;
    tick(1);
    for (int i = 0; i < 8; i++) check("dac_load", 26'(dac[i]), 26'hC);

    // mode 0, hit[0] two cycles, then a hit during PEND that must be dropped
    t0 = ts; hit = 8'h01; tick(2); hit = '0;
    sb.push_back(w0(3'd0, t0 + 9'd2, 11'd2));
    tick(4);
    hit = 8'h01; tick(2); hit = '0; tick(5);
    ro.shake_hands_next = 1'b1;
    #1 check("shl_pend", 26'(ro.shake_hands_last), 26'd0);
    tick(1);
    #1 check("shl_drained", 26'(ro.shake_hands_last), 26'd1);
    tick(1);
    ro.shake_hands_next = 1'b0;

    // ToT saturation
    t0 = ts; hit = 8'h20; tick(2100); hit = '0;
    sb.push_back(w0(3'd5, t0 + 9'd2, 11'h7FF));
    tick(5);
    ready(2);

    // pixels 0 and 3 pending plus upstream word
    t0 = ts; hit = 8'h09; tick(1); hit = 8'h08; tick(2); hit = '0; tick(5);
    up_w = {1'b1, 1'b0, 3'd6, 1'b0, 20'hABCDE};
    sb.push_back(w0(3'd0, t0 + 9'd2, 11'd1));
    sb.push_back(w0(3'd3, t0 + 9'd2, 11'd3));
    sb.push_back(up_w);
    ro.last_data = up_w;
    ro.shake_hands_next = 1'b1;
    #1 check("shl_blk0", 26'(ro.shake_hands_last), 26'd0);
    tick(1);
    #1 check("shl_blk1", 26'(ro.shake_hands_last), 26'd0);
    tick(1);
    #1 check("shl_open", 26'(ro.shake_hands_last), 26'd1);
    tick(1);
    ro.shake_hands_next = 1'b0;
    ro.last_data = '0;
    tick(3);
    check("arb_hold", ro.arbiter_data, up_w);
    ready(1);

    // mode 1 counting: a pulse outside the shutter is not counted
    mode = 1'b1;
    hit = 8'h01; tick(1); hit = '0; tick(5);
    shutter = 1'b1; tick(1);
    for (int k = 0; k < 3; k++) begin
      hit = (k < 2) ? 8'h03 : 8'h02;
      tick(1);
      hit = '0;
      tick(3);
    end
    tick(4);
    shutter = 1'b0;
    tick(2);
    sb.push_back(w1(3'd0, 20'd2));
    sb.push_back(w1(3'd1, 20'd3));
    ready(3);
    mode = 1'b0;

    // test pulse
    load_cfg(6'b111101);
    Apulse_en = 1'b1;
    tick(2);
`ifdef SUPER_PIXEL_TEST_PULSE_EN
    check("apulse_on", 26'(apulse), 26'hFF);
    t0 = ts; Dpulse = 1'b1; tick(1); Dpulse = 1'b0; tick(3);
    for (int i = 0; i < 8; i++) sb.push_back(w0(3'(i), t0, 11'd1));
    ready(9);
`else
    check("apulse_off", 26'(apulse), 26'h00);
    Dpulse = 1'b1; tick(1); Dpulse = 1'b0; tick(3);
    ready(1);
`endif
    check("dac_tp", 26'(dac[7]), 26'hD);

    // pixel clear during MEAS discards the measurement and keeps DAC codes
    hit = 8'h04; tick(4);
    config_info = cfg_word;
    rst_n_pixel = 1'b0; tick(1); rst_n_pixel = 1'b1;
    tick(2); hit = '0; tick(5);
    check("dac_keep", 26'(dac[2]), 26'(cfg_word[3:0]));
    ready(1);

    // global reset mid-MEAS
    up_w = {1'b1, 1'b1, 3'd2, 1'b1, 20'h12345};
    ro.last_data = up_w;
    sb.push_back(up_w);
    ready(1);
    ro.last_data = '0;
    hit = 8'h02; tick(5);
    rst = 1'b1; tick(2);
    check("mrst_arb", ro.arbiter_data, 26'd0);
    check("mrst_next_cfg", 26'(next_config_info), 26'd0);
    check("mrst_dac1", 26'(dac[1]), 26'd0);
    check("mrst_apulse", 26'(apulse), 26'd0);
    rst = 1'b0; hit = '0; Apulse_en = 1'b0;
    tick(6);
    ro.shake_hands_next = 1'b1;
    #1 check("shl_after_rst", 26'(ro.shake_hands_last), 26'd1);
    tick(1);
    ro.shake_hands_next = 1'b0;
    tick(1);
    check("sb_empty", 26'(sb.size()), 26'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
